en_pulse_gen: RTL and testbench
===============================

// Module: en_pulse_gen
// PURPOSE
//   Programmable enable-strobe generator. Sits directly upstream of the decade counter.
//   Its en output drives the counter's en input, so count rate and burst length are set by software.
//   Operating modes: continuous (free-run) or burst (N strobes, then a done pulse). Single clock domain.
// PARAMETERS
//   DIV_WIDTH    16  width of divide-ratio field and prescaler
//   BURST_WIDTH   8  width of burst-length field
//   DEFAULT_DIV  10  divide ratio loaded at reset; must fit in DIV_WIDTH
// PORTS
//   clk        in   1            system clock, all logic on posedge
//   rst_n      in   1            asynchronous active-low reset
//   cfg_valid  in   1            config offer; accepted when cfg_valid && cfg_ready at posedge
//   cfg_ready  out  1            high only in IDLE
//   cfg_div    in   DIV_WIDTH    clocks per strobe; 0 treated as 1
//   cfg_burst  in   BURST_WIDTH  strobes per run; 0 = continuous
//   start      in   1            level-sampled; launches a run from IDLE
//   stop       in   1            level-sampled; aborts a run
//   en         out  1            registered 1-cycle strobe to counter en
//   busy       out  1            high in RUN
//   done       out  1            registered 1-cycle pulse when a burst completes
// BEHAVIOUR
//   Reset values: en=0, busy=0, done=0, cfg_ready=1, div_q=DEFAULT_DIV, burst_q=0, prescaler=0, state=IDLE.
//   FSM IDLE -> RUN -> DONE -> IDLE (all outputs registered):
//     IDLE: start && !stop -> RUN, prescaler cleared, remaining<=burst_q. stop && start -> stays IDLE.
//     RUN : prescaler counts 0..div_q-1, wraps. en=1 in the cycle after prescaler==div_q-1 is sampled.
//           First strobe therefore appears div_q cycles after the start edge (div_q=1 -> every cycle).
//           Burst mode: each strobe decrements remaining. Strobe with remaining==1 -> DONE.
//           Continuous mode (burst_q==0): never leaves RUN except on stop.
//           stop -> IDLE at next edge. No done. No en in the following cycle, even if a wrap coincides.
//           start in RUN is ignored. cfg_valid in RUN is not accepted (cfg_ready=0).
//     DONE: exactly one cycle; done=1, busy=0, en=0 -> IDLE. start here is ignored.
//   Config: cfg_valid && cfg_ready captures cfg_div (0 mapped to 1) and cfg_burst.
//     Same-edge cfg accept + start: the run uses the NEW config.
//   Prescaler compare is unsigned, DIV_WIDTH bits. No arithmetic overflow: div_q>=1 always.
//   Reset mid-run: immediate return to reset values. Any pending burst is lost.
// CONFIGURATION
//   EN_PULSE_GEN_STATS_EN defined: extra port tick_count out 32.
//     Total en strobes since reset. Saturates at 32'hFFFF_FFFF. Reset 0.
//   Not defined: port and counter absent. All other behaviour identical.
// STRUCTURE
//   en_pulse_gen_pkg: state_e enum {IDLE, RUN, DONE}, DIV_MIN=1, STATS_WIDTH=32.
//   Sub-module en_prescaler: clear, enable, div -> registered wrap strobe. Instantiated once.
// TESTING
//   1 Reset, no cfg, start pulse -> en every 10 clk (DEFAULT_DIV), busy=1; counter reaches tc after 10 strobes.
//   2 cfg_div=3, cfg_burst=4, start -> 4 strobes 3 clk apart; done=1 one cycle after 4th strobe; busy=0; cfg_ready=1.
//   3 cfg_div=0, cfg_burst=0, start -> en high every cycle until stop; en=0 from cycle after stop, no done.
//   4 cfg_div=5, burst=2, stop asserted on the same cycle as the prescaler wrap -> no strobe emitted, IDLE next cycle.
//   5 start+stop together in IDLE -> stays IDLE. cfg_valid during RUN (div=7) -> not accepted, rate unchanged.
//   6 rst_n low mid-burst -> all outputs 0 asynchronously, div_q=10.
//     With EN_PULSE_GEN_STATS_EN: tick_count=0 after reset, 6 after a burst of 6.

Source files
------------

// File: rtl/en_pulse_gen_pkg.sv
// Shared types and constants for the en_pulse_gen strobe generator.
// Imported by the top; the optional statistics counter is sized from STATS_WIDTH.
package en_pulse_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DIV_MIN     = 1;
    localparam int STATS_WIDTH = 32;

endpackage

// File: rtl/en_prescaler.sv
// Free-running divider: counts 0..div-1 while enabled and emits a registered
// one-cycle wrap strobe in the cycle after the terminal count is sampled.
module en_prescaler #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 wrap
);

    logic [DIV_WIDTH-1:0] count_q, count_d;
    logic                 wrap_q, wrap_d;

    // div is never zero upstream, so div-1 cannot underflow
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            if (count_q == div - DIV_WIDTH'(1)) begin
                count_d = '0;
                wrap_d  = 1'b1;
            end else begin
                count_d = count_q + DIV_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign wrap = wrap_q;

endmodule

// File: rtl/en_pulse_gen.sv
// Programmable enable-strobe generator feeding the decade counter's en input.
// Define EN_PULSE_GEN_STATS_EN to add the saturating tick_count strobe counter port.
module en_pulse_gen
    import en_pulse_gen_pkg::*;
#(
    parameter int DIV_WIDTH   = 16,
    parameter int BURST_WIDTH = 8,
    parameter int DEFAULT_DIV = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [DIV_WIDTH-1:0]   cfg_div,
    input  logic [BURST_WIDTH-1:0] cfg_burst,
    input  logic                   start,
    input  logic                   stop,
    output logic                   en,
    output logic                   busy,
    output logic                   done
`ifdef EN_PULSE_GEN_STATS_EN
    ,
    output logic [STATS_WIDTH-1:0] tick_count
`endif
);

    state_e                 state_q, state_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic [BURST_WIDTH-1:0] burst_q, burst_d;
    logic [BURST_WIDTH-1:0] remaining_q, remaining_d;

    logic cfg_accept;
    logic launch;
    logic burst_mode;
    logic last_strobe;
    logic presc_enable;

    assign cfg_accept  = cfg_valid && (state_q == IDLE);
    assign launch      = (state_q == IDLE) && start && !stop;
    assign burst_mode  = (burst_q != '0);
    assign last_strobe = en && burst_mode && (remaining_q == BURST_WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            div_q       <= DIV_WIDTH'(DEFAULT_DIV);
            burst_q     <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            burst_q     <= burst_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (launch) state_d = RUN;
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (last_strobe) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A launch on the same edge as a config accept must use the incoming burst length
    always_comb begin
        div_d       = div_q;
        burst_d     = burst_q;
        remaining_d = remaining_q;
        if (cfg_accept) begin
            div_d   = (cfg_div == '0) ? DIV_WIDTH'(DIV_MIN) : cfg_div;
            burst_d = cfg_burst;
        end
        if (launch) begin
            remaining_d = cfg_accept ? cfg_burst : burst_q;
        end else if ((state_q == RUN) && en && burst_mode) begin
            remaining_d = remaining_q - BURST_WIDTH'(1);
        end
    end

    always_comb begin
        busy      = (state_q == RUN);
        done      = (state_q == DONE);
        cfg_ready = (state_q == IDLE);
    end

    // Only count while staying in RUN, so stop or burst end suppresses a coincident wrap
    assign presc_enable = (state_q == RUN) && (state_d == RUN);

    en_prescaler #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (launch),
        .enable(presc_enable),
        .div   (div_q),
        .wrap  (en)
    );

`ifdef EN_PULSE_GEN_STATS_EN
    logic [STATS_WIDTH-1:0] tick_count_q, tick_count_d;

    always_comb begin
        tick_count_d = tick_count_q;
        if (en && (tick_count_q != '1)) begin
            tick_count_d = tick_count_q + STATS_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_count_q <= '0;
        end else begin
            tick_count_q <= tick_count_d;
        end
    end

    assign tick_count = tick_count_q;
`endif

endmodule

// File: tb/tb_en_pulse_gen.sv
// Directed self-checking bench for en_pulse_gen; inputs change and outputs are
// sampled on the falling clock edge. Honours EN_PULSE_GEN_STATS_EN if defined.
module tb_en_pulse_gen;

    logic        clk = 1'b0;
    logic        rstN;
    logic        cfgValid;
    logic        cfgReady;
    logic [15:0] cfgDiv;
    logic [7:0]  cfgBurst;
    logic        startIn;
    logic        stopIn;
    logic        enOut;
    logic        busyOut;
    logic        doneOut;
`ifdef EN_PULSE_GEN_STATS_EN
    logic [31:0] tickCount;
`endif

    int total = 0;
    int bad   = 0;
    int strobes;

    always #5 clk = ~clk;

    en_pulse_gen dut (
        .clk      (clk),
        .rst_n    (rstN),
        .cfg_valid(cfgValid),
        .cfg_ready(cfgReady),
        .cfg_div  (cfgDiv),
        .cfg_burst(cfgBurst),
        .start    (startIn),
        .stop     (stopIn),
        .en       (enOut),
        .busy     (busyOut),
        .done     (doneOut)
`ifdef EN_PULSE_GEN_STATS_EN
        ,
        .tick_count(tickCount)
`endif
    );

    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic [7:0] b,
                                 input logic s, input logic p);
        cfgValid = v;
        cfgDiv   = d;
        cfgBurst = b;
        startIn  = s;
        stopIn   = p;
    endtask

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic checkWord(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        applyStimulus(1'b0, 16'd0, 8'd0, 1'b0, 1'b0);
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_en", enOut, 1'b0);
        checkOutput("rst_busy", busyOut, 1'b0);
        checkOutput("rst_done", doneOut, 1'b0);
        checkOutput("rst_cfg_ready", cfgReady, 1'b1);
        rstN = 1'b1;
        @(negedge clk);

        $display("[TB] default divide ratio, continuous");
        applyStimulus(1'b0, 16'd0, 8'd0, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 16'd0, 8'd0, 1'b0, 1'b0);
        checkOutput("t1_busy", busyOut, 1'b1);
        checkOutput("t1_en0", enOut, 1'b0);
        strobes = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            checkOutput($sformatf("t1_en_%0d", i), enOut, (i % 10) == 0);
            if (enOut === 1'b1) strobes++;
        end
        checkWord("t1_strobes_to_tc", strobes, 10);
        applyStimulus(1'b0, 16'd0, 8'd0, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 16'd0, 8'd0, 1'b0, 1'b0);
        checkOutput("t1_stop_en", enOut, 1'b0);
        checkOutput("t1_stop_busy", busyOut, 1'b0);
        checkOutput("t1_stop_done", doneOut, 1'b0);

        $display("[TB] burst of 4 at div 3");
        applyStimulus(1'b1, 16'd3, 8'd4, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 16'd0, 8'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            checkOutput($sformatf("t2_en_%0d", i), enOut, ((i % 3) == 0) && (i <= 12));
            checkOutput($sformatf("t2_done_%0d", i), doneOut, i == 13);
            checkOutput($sformatf("t2_busy_%0d", i), busyOut, i <= 12);
            checkOutput($sformatf("t2_ready_%0d", i), cfgReady, i >= 14);
        end

        $display("[TB] div 0 continuous then stop");
        applyStimulus(1'b1, 16'd0, 8'd0, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 16'd0, 8'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            checkOutput($sformatf("t3_en_%0d", i), enOut, 1'b1);
        end
        applyStimulus(1'b0, 16'd0, 8'd0, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 16'd0, 8'd0, 1'b0, 1'b0);
        checkOutput("t3_stop_en", enOut, 1'b0);
        checkOutput("t3_stop_busy", busyOut, 1'b0);
        checkOutput("t3_stop_done", doneOut, 1'b0);
        @(negedge clk);
        checkOutput("t3_after_en", enOut, 1'b0);
        checkOutput("t3_after_done", doneOut, 1'b0);

        $display("[TB] stop coincident with wrap");
        applyStimulus(1'b1, 16'd5, 8'd2, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 16'd0, 8'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("t4_en_%0d", i), enOut, 1'b0);
        end
        applyStimulus(1'b0, 16'd0, 8'd0, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 16'd0, 8'd0, 1'b0, 1'b0);
        checkOutput("t4_wrap_en", enOut, 1'b0);
        checkOutput("t4_wrap_busy", busyOut, 1'b0);
        checkOutput("t4_wrap_ready", cfgReady, 1'b1);
        checkOutput("t4_wrap_done", doneOut, 1'b0);
        @(negedge clk);
        checkOutput("t4_after_en", enOut, 1'b0);
        checkOutput("t4_after_done", doneOut, 1'b0);

        $display("[TB] start+stop in idle, config during run");
        applyStimulus(1'b0, 16'd0, 8'd0, 1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 16'd0, 8'd0, 1'b0, 1'b0);
        checkOutput("t5_ss_busy", busyOut, 1'b0);
        checkOutput("t5_ss_ready", cfgReady, 1'b1);
        checkOutput("t5_ss_en", enOut, 1'b0);
        applyStimulus(1'b1, 16'd4, 8'd0, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 16'd0, 8'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            checkOutput($sformatf("t5_en_%0d", i), enOut, (i % 4) == 0);
            checkOutput($sformatf("t5_ready_%0d", i), cfgReady, 1'b0);
            if (i == 2) applyStimulus(1'b1, 16'd7, 8'd0, 1'b0, 1'b0);
            if (i == 3) applyStimulus(1'b0, 16'd0, 8'd0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 16'd0, 8'd0, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 16'd0, 8'd0, 1'b0, 1'b0);
        checkOutput("t5_stop_busy", busyOut, 1'b0);

        $display("[TB] reset, burst of 6, reset mid-burst");
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
`ifdef EN_PULSE_GEN_STATS_EN
        checkWord("t6_ticks_reset", tickCount, 32'd0);
`endif
        applyStimulus(1'b1, 16'd2, 8'd6, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 16'd0, 8'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            checkOutput($sformatf("t6_en_%0d", i), enOut, ((i % 2) == 0) && (i <= 12));
            checkOutput($sformatf("t6_done_%0d", i), doneOut, i == 13);
        end
`ifdef EN_PULSE_GEN_STATS_EN
        checkWord("t6_ticks_burst", tickCount, 32'd6);
`endif
        applyStimulus(1'b0, 16'd0, 8'd0, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 16'd0, 8'd0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("t6_mid_en", enOut, 1'b1);
        checkOutput("t6_mid_busy", busyOut, 1'b1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("t6_async_en", enOut, 1'b0);
        checkOutput("t6_async_busy", busyOut, 1'b0);
        checkOutput("t6_async_done", doneOut, 1'b0);
        checkOutput("t6_async_ready", cfgReady, 1'b1);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(1'b0, 16'd0, 8'd0, 1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 16'd0, 8'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            checkOutput($sformatf("t6_div10_en_%0d", i), enOut, i == 10);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
